// File: rtl/irq_src_cond_pkg.sv
// rtl/irq_src_cond_pkg.sv - core-wide IRQ defines and debounce sizing helpers
// Optional feature macro: IRQ_DEBOUNCE_EN (per-line debounce counters).
`ifndef NIRQ
`define NIRQ 4
`endif
`ifndef NBIT_IRQ
`define NBIT_IRQ 2
`endif
`ifndef IRQ_DB_CYCLES
`define IRQ_DB_CYCLES 16
`endif

package irq_src_cond_pkg;

  localparam int NIRQ_W = `NIRQ;
  localparam int DB_MIN = 1;
  localparam int DB_MAX = 65535;

  // Keeps an out-of-range override from producing a zero-width or wrapping counter.
  function automatic int db_clamp(input int db);
    if (db < DB_MIN) return DB_MIN;
    if (db > DB_MAX) return DB_MAX;
    return db;
  endfunction

  // Bits needed to hold db-1; never narrower than one bit.
  function automatic int db_cnt_width(input int db);
    return (db <= 2) ? 1 : $clog2(db);
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// rtl/irq_debounce.sv - single-line synchronizer, debounce and rising-edge detect
// With IRQ_DEBOUNCE_EN undefined the counter is absent and the level follows s2 every edge.
module irq_debounce
  import irq_src_cond_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_nxt;

`ifdef IRQ_DEBOUNCE_EN
  localparam int CW = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // A change is accepted on the DB_CYCLES-th consecutive differing sample.
  always_comb begin
    lvl_nxt = lvl;
    cnt_nxt = '0;
    if (s2 != lvl) begin
      if (cnt == CNT_LAST) begin
        lvl_nxt = s2;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  assign lvl_nxt = s2;
`endif

  assign rise = lvl_nxt & ~lvl;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      lvl <= lvl_nxt;
    end
  end

endmodule

// File: rtl/irq_src_cond.sv
// rtl/irq_src_cond.sv - conditions raw interrupt levels into held pending requests
// Debounce length is DB_CYCLES when IRQ_DEBOUNCE_EN is defined, otherwise one sample.
module irq_src_cond
  import irq_src_cond_pkg::*;
#(
  parameter int DB_CYCLES = `IRQ_DB_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [`NIRQ-1:0]  irq_raw,
  input  logic              ovf_clr,
  output logic [`NIRQ-1:0]  irq_src,
  output logic [`NIRQ-1:0]  ovf
);

  localparam int DB_EFF = db_clamp(DB_CYCLES);

  logic [NIRQ_W-1:0] rise;
  logic [NIRQ_W-1:0] pend;
  logic [NIRQ_W-1:0] pend_nxt;
  logic [NIRQ_W-1:0] ovf_r;
  logic [NIRQ_W-1:0] ovf_nxt;

  for (genvar i = 0; i < NIRQ_W; i++) begin : g_line
    irq_debounce #(
      .DB_CYCLES (DB_EFF)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (irq_raw[i]),
      .rise  (rise[i])
    );
  end

  // A fresh rise is OR-ed in after the enabled clear so it survives that edge;
  // a rise onto a still-pending line with no enabled edge is a lost request.
  always_comb begin
    pend_nxt = (en ? '0 : pend) | rise;
    ovf_nxt  = (ovf_clr ? '0 : ovf_r) | (rise & pend & ~{NIRQ_W{en}});
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      ovf_r <= '0;
    end else begin
      pend  <= pend_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign irq_src = pend;
  assign ovf     = ovf_r;

endmodule

// File: doc/irq_src_cond.md
IRQ_SRC_COND -- requirements
Module: irq_src_cond

Interface
REQ-001 Parameter: DB_CYCLES, default 16, number of consecutive stable samples needed to accept a level change; legal range 1..65535.
REQ-002 Port: clk  input  1  system clock; all state updates on the falling edge, matching the interrupt register block it feeds.
REQ-003 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port: en  input  1  core-advance enable; high means the downstream interrupt register samples irq_src at this falling edge.
REQ-005 Port: irq_raw  input  `NIRQ  asynchronous interrupt request levels (buttons/peripherals), active-high.
REQ-006 Port: ovf_clr  input  1  synchronous clear of all overflow flags.
REQ-007 Port: irq_src  output  `NIRQ  pending interrupt requests to the interrupt register block; equals the pend register.
REQ-008 Port: ovf  output  `NIRQ  sticky per-line flag: a request was lost.

Function
REQ-009 Per line, irq_raw SHALL pass through a two-flop synchronizer (s1, s2) clocked on negedge clk.
REQ-010 Per line, debounce: cnt increments while s2 != lvl; cnt returns to 0 when s2 == lvl; when s2 != lvl and cnt == DB_CYCLES-1, lvl <= s2 and cnt <= 0.
REQ-011 rise[i] SHALL be asserted combinationally exactly in the cycle in which lvl[i] is about to go 0->1; falling transitions produce no request.
REQ-012 pend SHALL update as pend <= (en ? 0 : pend) | rise, so a request is held until one enabled edge has presented it downstream.
REQ-013 A rise coinciding with an enabled edge SHALL leave pend set (new request survives the clear).
REQ-014 ovf[i] SHALL set when rise[i] & pend[i] & ~en; ovf_clr clears all bits; simultaneous set and clear: set wins.
REQ-015 Latency: irq_raw[i] high and stable from before falling edge N -> irq_src[i] high after edge N+1+DB_CYCLES.
REQ-016 Glitch rejection: a pulse shorter than DB_CYCLES samples at s2 SHALL produce no irq_src assertion.
REQ-017 cnt width SHALL be sized to hold DB_CYCLES-1; cnt never wraps.
REQ-018 Lines SHALL be fully independent; simultaneous rises on several lines set all corresponding pend bits in the same edge.

Reset
REQ-019 rst_n low SHALL immediately clear s1, s2, lvl, cnt, pend and ovf; irq_src = 0, ovf = 0.
REQ-020 Reset during a debounce count SHALL discard it; the line must re-qualify for the full DB_CYCLES after release.
REQ-021 An input held high through reset release SHALL yield exactly one request, 1+DB_CYCLES edges after release.

Configuration
REQ-022 Macro IRQ_DEBOUNCE_EN defined: debounce per REQ-010 with DB_CYCLES.
REQ-023 IRQ_DEBOUNCE_EN undefined: no counters; lvl <= s2 each edge (behaves as DB_CYCLES = 1); DB_CYCLES is ignored; latency = 2 edges.

Structure
REQ-024 `NIRQ and `NBIT_IRQ SHALL come from Core.vh; the default debounce count SHALL be added there as `IRQ_DB_CYCLES.
REQ-025 One sub-module irq_debounce (single-line synchronizer + debounce + rise) SHALL be instantiated `NIRQ times; pend/ovf logic stays in the top module.

Verification
REQ-026 DB_CYCLES=4, en=1, irq_raw[0] 0->1 before edge 10 -> irq_src[0]=1 after edge 15 only, cleared after edge 16, ovf=0.
REQ-027 DB_CYCLES=4, irq_raw[1] high for 3 cycles then low -> irq_src stays 0 throughout.
REQ-028 en=0, two qualified rises on line 2 separated by 10 low cycles -> irq_src[2] held high, ovf[2]=1 after second rise; en=1 one edge -> irq_src[2]=0; ovf_clr -> ovf=0.
REQ-029 Rise on line 0 at the same edge as en=1 clearing a pending line 0 -> irq_src[0] remains 1 after that edge.
REQ-030 rst_n low asynchronously mid-count (cnt=2) with irq_raw high -> all outputs 0 at once; after release, request after exactly 1+DB_CYCLES edges.
REQ-031 Build without IRQ_DEBOUNCE_EN, 1-cycle pulse on irq_raw[3] -> irq_src[3]=1 two edges later.
